seg_scan: RTL
=============

# seg_scan

Eight-digit seven-segment refresh stage that sits directly downstream of the processor core's display outputs. The core's syscall unit drives a digit-select byte and a segment byte for a single cycle per write; this block captures each write into a per-digit segment buffer and time-multiplexes all eight digits onto the board's common-anode display. As a result, every digit the program has written stays visible, not only the one most recently written.

## Interface
- DIV_W, 16: prescaler width; each digit slot lasts 2^DIV_W clock cycles.
- BLANK_CYC, 4: dead-time cycles at the start of each slot; used only when blanking is compiled in; must be less than 2^DIV_W.
- i_clk  in  1  system clock, shared with the core.
- i_rst  in  1  reset: synchronous, active-high.
- i_ctl  in  8  digit-select from core; bit n=1 writes digit n this cycle.
- i_disp  in  8  segment pattern from core; active-high (bit0=a … bit6=g, bit7=dp).
- o_an  out  8  digit anode enables to board, active-low, registered.
- o_seg  out  8  segment cathodes to board, active-low, registered.
- o_frame  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- Digit buffer: eight 8-bit registers buf[0..7].
  - Every cycle, each buf[n] with i_ctl[n]=1 loads i_disp.
  - Multiple bits set means every selected digit loads the same value in the same cycle.
  - i_ctl=8'h00 means no write.
  - The buffer has no handshake; writes are never dropped or stalled.
- Prescaler: DIV_W-bit up-counter `pre`, free-running, wraps from 2^DIV_W-1 to 0.
- Scan index: 3-bit `idx`.
  - Increments in the cycle `pre` is at terminal count, so the new idx is visible together with pre=0.
  - Wraps from 7 to 0.
- Output register, updated every cycle from the current `pre`/`idx` and the buffer:
  - o_an = ~(8'b1 << idx).
  - o_seg = ~buf[idx], using the buffer value as it stands after this cycle's write (write-through).
- Frame pulse: o_frame=1 for exactly one cycle, the first cycle in which the outputs show idx=0 after idx was 7.
- Reset state:
  - buf[*] = 8'h00.
  - pre = 0, idx = 0.
  - o_an = 8'hFF, o_seg = 8'hFF, o_frame = 0.
  - Reset mid-scan or mid-write discards the write; all state returns to the reset state on the next edge.

## Timing
- Write-to-display latency:
  - A write to buf[idx] in cycle t appears on o_seg at edge t+1.
  - A write to any other digit appears when that digit's slot next starts.
- The first cycle after reset release shows digit 0 (o_an=8'hFE) with blank segments (8'hFF).
- Full scan period: 8·2^DIV_W cycles. Slot boundaries are exact, with no skipped or doubled slots.
- Simultaneous write and slot change: the outgoing digit keeps its old slot timing; the written value is stored regardless and is displayed whenever that digit is next scanned.
- o_frame period is 8·2^DIV_W cycles, starting 8·2^DIV_W cycles after reset release. No pulse is emitted at reset.

## Configuration
- SEG_SCAN_BLANK_EN defined:
  - o_an = 8'hFF while pre < BLANK_CYC; o_seg still follows the current digit during that window.
  - Removes ghosting between adjacent digits.
- SEG_SCAN_BLANK_EN undefined:
  - The anode switches directly at the slot boundary.
  - BLANK_CYC is ignored; no comparator logic is built.

## Test plan
All scenarios use DIV_W=2 (4-cycle slots) and BLANK_CYC=1.
- Reset then idle 40 cycles:
  - o_an cycles FE, FD, FB, …, 7F, each held 4 cycles.
  - o_seg stays FF.
  - o_frame pulses once every 32 cycles, starting 32 cycles after reset release.
- Write i_ctl=8'h04, i_disp=8'h3F (digit 2 shows "0"):
  - Slots 0, 1, 3–7 show o_seg=FF.
  - Slot 2 shows o_an=FB, o_seg=C0.
- Write i_ctl=8'hFF, i_disp=8'h06 in one cycle:
  - Every slot shows o_seg=F9.
  - A later write of i_ctl=8'h01, i_disp=8'h5B changes only slot 0, to A4.
- Write to the currently scanned digit (idx=3, i_ctl=8'h08, i_disp=8'h7F) mid-slot:
  - o_seg becomes 80 on the next edge.
  - o_an stays F7 until the slot ends.
- Assert i_rst for 1 cycle mid-scan (idx=5) after writes:
  - Next cycle o_an=FF, o_seg=FF.
  - Scan restarts at digit 0 with all buffer entries cleared.
- SEG_SCAN_BLANK_EN defined:
  - The first cycle of each slot has o_an=FF; the remaining 3 cycles carry the one-hot-low anode.
- SEG_SCAN_BLANK_EN undefined:
  - No FF anode cycles after reset.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: eight-digit seven-segment refresh stage.
// Captures single-cycle digit writes from the core into a per-digit buffer
// and time-multiplexes all eight digits onto a common-anode display.
// Optional feature: define SEG_SCAN_BLANK_EN to blank the anodes for the
// first BLANK_CYC cycles of every slot (anti-ghosting dead time).
module seg_scan #(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_ctl,
  input  logic [7:0] i_disp,
  output logic [7:0] o_an,
  output logic [7:0] o_seg,
  output logic       o_frame
);

  // The dead time must leave part of the slot lit.
  if (BLANK_CYC >= (1 << DIV_W)) begin : g_bad_blank
    $error("seg_scan: BLANK_CYC must be less than 2^DIV_W");
  end

  logic [7:0][7:0]   seg_buf;
  logic [DIV_W-1:0]  pre;
  logic [2:0]        idx;
  logic [2:0]        idx_q;   // digit index currently shown on the outputs
  logic              pre_tc;
  logic [7:0]        cur_seg;
  logic [7:0]        an_nxt;

  assign pre_tc = &pre;

  // Write-through: a write to the scanned digit shows on the very next edge.
  assign cur_seg = i_ctl[idx] ? i_disp : seg_buf[idx];

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);
  assign an_nxt = (pre < BLANK_V) ? 8'hFF : ~(8'h01 << idx);
`else
  assign an_nxt = ~(8'h01 << idx);
`endif

  // Digit buffer: every selected digit loads the segment byte, no handshake.
  for (genvar n = 0; n < 8; n++) begin : g_digit
    always_ff @(posedge i_clk) begin
      if (i_rst)         seg_buf[n] <= 8'h00;
      else if (i_ctl[n]) seg_buf[n] <= i_disp;
    end
  end

  // Prescaler and scan index; idx advances together with pre wrapping to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre <= '0;
      idx <= 3'd0;
    end else begin
      pre <= pre + 1'b1;
      if (pre_tc) idx <= idx + 3'd1;
    end
  end

  // Registered board outputs; frame pulses when the shown digit wraps 7 -> 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an    <= 8'hFF;
      o_seg   <= 8'hFF;
      o_frame <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      o_an    <= an_nxt;
      o_seg   <= ~cur_seg;
      o_frame <= (idx == 3'd0) && (idx_q == 3'd7);
      idx_q   <= idx;
    end
  end

endmodule
